acq_started_poller: RTL and testbench

- Avalon-MM read initiator that periodically polls the 1-bit acquisition-started status PIO (address 0, fixed read latency, no readdatavalid).
- Converts the polled level into a registered status, a one-cycle rising-edge event, and a timestamp of that edge for the acquisition control logic.
- Sits between the status PIO slave port and the DE4 acquisition sequencer; replaces CPU polling of the same register.

---
 rtl/acq_started_poller_if.sv | 26 ++
 rtl/acq_started_poller.sv | 154 +++++++++++++++
 tb/tb_acq_started_poller.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/acq_started_poller_if.sv
// Avalon-MM read channel between the acquisition-started poller (master)
// and the status PIO slave port.
//   avm_address     : read address, always 0 (master -> slave)
//   avm_read        : read request (master -> slave)
//   avm_waitrequest : slave stall (slave -> master)
//   avm_readdata    : 1-bit PIO level, fixed read latency (slave -> master)
interface acq_started_poller_if;
    logic [1:0] avm_address;
    logic       avm_read;
    logic       avm_waitrequest;
    logic       avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );
endinterface

// File: rtl/acq_started_poller.sv
// Periodically polls the acquisition-started status PIO over Avalon-MM and
// turns the polled level into a registered status, a one-cycle rising-edge
// pulse and a timestamp of that edge.
// Ports:
//   clk             : system clock, rising edge
//   reset           : asynchronous, active-high
//   enable          : polling enable (level)
//   avm             : Avalon-MM read master (address/read/waitrequest/readdata)
//   acq_started     : last successfully polled level
//   acq_start_pulse : one-cycle pulse on a polled 0->1 transition
//   acq_start_ts    : free-running counter value at the rising capture
//   timeout_err     : sticky, set when a stalled read is abandoned
//
// state | meaning
// IDLE  | polling disabled, no request outstanding
// READ  | avm_read asserted, waiting for waitrequest low
// LAT   | read accepted, waiting out the fixed read latency
// GAP   | idle spacing between polls
module acq_started_poller #(
    parameter int POLL_INTERVAL = 16,
    parameter int READ_LATENCY  = 1,
    parameter int TIMEOUT       = 64,
    parameter int TS_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    acq_started_poller_if.master      avm,
    output logic                      acq_started,
    output logic                      acq_start_pulse,
    output logic [TS_WIDTH-1:0]       acq_start_ts,
    output logic                      timeout_err
);

    localparam int STALL_W = $clog2(TIMEOUT + 1);
    localparam int LAT_W   = $clog2(READ_LATENCY + 1);
    localparam int GAP_W   = $clog2(POLL_INTERVAL + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_LAT  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [STALL_W-1:0]  stall_cnt;
    logic [LAT_W-1:0]    lat_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [TS_WIDTH-1:0] ts_cnt;

    logic accept;
    logic stall_tc;
    logic lat_tc;
    logic gap_tc;
    logic capture;

    assign accept   = (state_q == ST_READ) && !avm.avm_waitrequest;
    // Fires on the edge at which the stall count reaches TIMEOUT.
    assign stall_tc = (state_q == ST_READ) && avm.avm_waitrequest &&
                      (stall_cnt == STALL_W'(TIMEOUT - 1));
    assign lat_tc   = (lat_cnt == LAT_W'(1));
    assign gap_tc   = (gap_cnt == GAP_W'(1));
    assign capture  = (state_q == ST_LAT) && lat_tc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Once a request is on the bus it is never withdrawn by enable; enable
    // only decides where to go after the transaction ends.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_READ;
            end
            ST_READ: begin
                if (accept)        state_d = ST_LAT;
                else if (stall_tc) state_d = ST_GAP;
            end
            ST_LAT: begin
                if (lat_tc) state_d = enable ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                if (gap_tc) state_d = enable ? ST_READ : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        avm.avm_read    = (state_q == ST_READ);
        avm.avm_address = 2'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_cnt    <= '0;
            stall_cnt <= '0;
            lat_cnt   <= '0;
            gap_cnt   <= '0;
        end else begin
            ts_cnt    <= ts_cnt + 1'b1;
            stall_cnt <= '0;
            case (state_q)
                ST_READ: begin
                    if (avm.avm_waitrequest && !stall_tc) stall_cnt <= stall_cnt + 1'b1;
                    if (accept)   lat_cnt <= LAT_W'(READ_LATENCY);
                    if (stall_tc) gap_cnt <= GAP_W'(POLL_INTERVAL);
                end
                ST_LAT: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    if (lat_tc) gap_cnt <= GAP_W'(POLL_INTERVAL);
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // acq_started doubles as the previous-sample register: it only changes
    // on a successful capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acq_started     <= 1'b0;
            acq_start_pulse <= 1'b0;
            acq_start_ts    <= '0;
            timeout_err     <= 1'b0;
        end else begin
            acq_start_pulse <= 1'b0;
            if (capture) begin
                acq_started <= avm.avm_readdata;
                if (avm.avm_readdata && !acq_started) begin
                    acq_start_pulse <= 1'b1;
                    acq_start_ts    <= ts_cnt;
                end
            end
            if (stall_tc) begin
                timeout_err <= 1'b1;
            end else if ((state_q == ST_IDLE) && !enable) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_acq_started_poller.sv
module tb_acq_started_poller;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        acq_started;
    logic        acq_start_pulse;
    logic [31:0] acq_start_ts;
    logic        timeout_err;

    int checks;
    int errors;
    int pulse_cnt;
    logic [31:0] cyc;

    acq_started_poller_if bus ();

    acq_started_poller #(
        .POLL_INTERVAL(16),
        .READ_LATENCY (1),
        .TIMEOUT      (64),
        .TS_WIDTH     (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .avm            (bus),
        .acq_started    (acq_started),
        .acq_start_pulse(acq_start_pulse),
        .acq_start_ts   (acq_start_ts),
        .timeout_err    (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference free-running cycle count.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 32'd0;
        else       cyc <= cyc + 32'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (acq_start_pulse === 1'b1) pulse_cnt++;
    endtask

    task automatic wait_read(input logic lvl, input int max, input string tag);
        int n;
        n = 0;
        while (bus.avm_read !== lvl && n < max) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.avm_read), 32'(lvl));
    endtask

    // One read stalled 5 cycles; returns with the capture just observed.
    task automatic stalled_read(input logic data, input logic prev, input string tag);
        int bad;
        wait_read(1'b0, 40, {tag, "_idle"});
        bus.avm_waitrequest = 1'b1;
        bus.avm_readdata    = data;
        wait_read(1'b1, 40, {tag, "_issue"});
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.avm_read !== 1'b1 || bus.avm_address !== 2'd0) bad++;
        end
        chk({tag, "_held"}, 32'(bad), 0);
        bus.avm_waitrequest = 1'b0;
        tick();
        chk({tag, "_lat_read"}, 32'(bus.avm_read), 0);
        chk({tag, "_lat_status"}, 32'(acq_started), 32'(prev));
        tick();
        chk({tag, "_capture"}, 32'(acq_started), 32'(data));
        chk({tag, "_pulse"}, 32'(acq_start_pulse), 32'(data & ~prev));
        if (data && !prev) chk({tag, "_ts"}, acq_start_ts, cyc - 32'd1);
        chk({tag, "_terr"}, 32'(timeout_err), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        int pc;
        logic [31:0] ts_hold;

        checks    = 0;
        errors    = 0;
        pulse_cnt = 0;
        reset               = 1'b1;
        enable              = 1'b0;
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata    = 1'b0;

        // Reset values
        tick();
        tick();
        chk("rst_read", 32'(bus.avm_read), 0);
        chk("rst_addr", 32'(bus.avm_address), 0);
        chk("rst_status", 32'(acq_started), 0);
        chk("rst_pulse", 32'(acq_start_pulse), 0);
        chk("rst_ts", acq_start_ts, 0);
        chk("rst_terr", 32'(timeout_err), 0);
        reset = 1'b0;
        tick();
        tick();
        chk("disabled_read", 32'(bus.avm_read), 0);

        // Plain polling, data 0: read one cycle after enable, period 18
        enable = 1'b1;
        tick();
        chk("first_read", 32'(bus.avm_read), 1);
        bad = 0;
        for (int i = 0; i < 17; i++) begin
            tick();
            if (bus.avm_read !== 1'b0) bad++;
        end
        chk("period_quiet", 32'(bad), 0);
        tick();
        chk("period_18", 32'(bus.avm_read), 1);
        chk("data0_status", 32'(acq_started), 0);
        chk("data0_pulses", 32'(pulse_cnt), 0);

        // Rising input at counter 100
        n = 0;
        while (cyc != 32'd100 && n < 200) begin
            tick();
            n++;
        end
        chk("reach_cyc100", cyc, 100);
        bus.avm_readdata = 1'b1;
        n = 0;
        while (acq_start_pulse !== 1'b1 && n < 25) begin
            tick();
            n++;
        end
        chk("rise_pulse", 32'(acq_start_pulse), 1);
        chk("rise_ts", acq_start_ts, cyc - 32'd1);
        chk("rise_status", 32'(acq_started), 1);
        ts_hold = acq_start_ts;
        tick();
        chk("rise_pulse_1cyc", 32'(acq_start_pulse), 0);
        for (int i = 0; i < 40; i++) tick();
        chk("rise_single", 32'(pulse_cnt), 1);
        chk("rise_ts_hold", acq_start_ts, ts_hold);

        // Stalled reads (5 cycles of waitrequest)
        stalled_read(1'b0, 1'b1, "stall_fall");
        stalled_read(1'b1, 1'b0, "stall_rise");

        // Waitrequest stuck high -> timeout
        wait_read(1'b0, 40, "to_idle");
        bus.avm_waitrequest = 1'b1;
        bus.avm_readdata    = 1'b0;
        wait_read(1'b1, 40, "to_issue");
        bad = 0;
        for (int i = 0; i < 63; i++) begin
            tick();
            if (bus.avm_read !== 1'b1) bad++;
        end
        chk("to_held63", 32'(bad), 0);
        chk("to_err_before", 32'(timeout_err), 0);
        tick();
        chk("to_drop", 32'(bus.avm_read), 0);
        chk("to_err", 32'(timeout_err), 1);
        chk("to_status_kept", 32'(acq_started), 1);
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.avm_read !== 1'b0) bad++;
        end
        chk("to_gap_quiet", 32'(bad), 0);
        tick();
        chk("to_reissue16", 32'(bus.avm_read), 1);
        enable = 1'b0;
        n = 0;
        while (timeout_err !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        chk("to_err_clear", 32'(timeout_err), 0);
        chk("to_status_end", 32'(acq_started), 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.avm_read !== 1'b0) bad++;
        end
        chk("to_disabled_quiet", 32'(bad), 0);

        // Enable dropped during a stalled read
        bus.avm_waitrequest = 1'b1;
        bus.avm_readdata    = 1'b0;
        enable              = 1'b1;
        wait_read(1'b1, 5, "drop_issue");
        tick();
        tick();
        tick();
        enable = 1'b0;
        tick();
        tick();
        chk("drop_held", 32'(bus.avm_read), 1);
        bus.avm_waitrequest = 1'b0;
        tick();
        chk("drop_accept", 32'(bus.avm_read), 0);
        chk("drop_lat_status", 32'(acq_started), 1);
        tick();
        chk("drop_capture", 32'(acq_started), 0);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.avm_read !== 1'b0) bad++;
        end
        chk("drop_no_reads", 32'(bad), 0);

        // Reset while in LAT with readdata=1
        bus.avm_readdata = 1'b1;
        enable           = 1'b1;
        wait_read(1'b1, 5, "rl_issue");
        tick();
        tick();
        chk("rl_pre_pulse", 32'(acq_start_pulse), 1);
        chk("rl_pre_status", 32'(acq_started), 1);
        wait_read(1'b1, 25, "rl_issue2");
        tick();
        chk("rl_in_lat", 32'(bus.avm_read), 0);
        #2;
        reset = 1'b1;
        #1;
        chk("rl_async_read", 32'(bus.avm_read), 0);
        chk("rl_async_status", 32'(acq_started), 0);
        chk("rl_async_ts", acq_start_ts, 0);
        chk("rl_async_pulse", 32'(acq_start_pulse), 0);
        chk("rl_async_terr", 32'(timeout_err), 0);
        tick();
        tick();
        chk("rl_hold_status", 32'(acq_started), 0);
        reset = 1'b0;
        pc = pulse_cnt;
        tick();
        chk("rl_reissue", 32'(bus.avm_read), 1);
        tick();
        tick();
        chk("rl_post_pulse", 32'(acq_start_pulse), 1);
        chk("rl_post_status", 32'(acq_started), 1);
        chk("rl_post_ts", acq_start_ts, 2);
        tick();
        chk("rl_post_pulse_end", 32'(acq_start_pulse), 0);
        chk("rl_pulse_count", 32'(pulse_cnt - pc), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
